// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port IDs,
// the latched request record and the legality rule applied at grant time.
package mem_arb_pkg;

    localparam int DEFAULT_TIMEOUT = 64;
    localparam int DEFAULT_CNT_W   = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        rd;
        logic        wr;
    } req_t;

    // Misaligned word addresses and simultaneous read+write never reach memory.
    function automatic logic is_illegal(input req_t r);
        return r.addr[0] || (r.rd && r.wr);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-requester round-robin picker; on a tie the requester
// that was not served last wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       valid
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between the instruction and data ports: one
// transaction at a time, round-robin on ties, watchdog on the memory wait.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    output logic        i_err,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    input  logic        d_rd,
    input  logic        d_wr,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    output logic        d_err,
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_data_out,
    input  logic        m_done,
    input  logic        m_stall,
    input  logic        m_err
);

    state_t           state;
    state_t           next_state;
    req_t             lat_q;
    req_t             win_req;
    req_t             cur_req;
    port_t            grant_q;
    port_t            last_q;
    port_t            win_port;
    port_t            eff_grant;
    logic [CNT_W-1:0] wd_q;
    logic [1:0]       req_vec;
    logic [1:0]       gnt;
    logic             req_valid;
    logic             fin;
    logic             rsp_err;
    logic [15:0]      rsp_data;
    logic [15:0]      m_addr_nxt;
    logic [15:0]      m_data_in_nxt;
    logic             m_rd_nxt;
    logic             m_wr_nxt;
    logic             i_done_nxt;
    logic             d_done_nxt;
    logic             unused_m_stall;

    // Done is authoritative; the memory stall is deliberately ignored.
    assign unused_m_stall = m_stall;

    assign req_vec = {d_rd | d_wr, i_rd};

    arb_rr2 u_arb (
        .req   (req_vec),
        .last  (last_q == PORT_DATA),
        .gnt   (gnt),
        .valid (req_valid)
    );

    always_comb begin
        win_port = PORT_INST;
        win_req  = '{addr: i_addr, data: 16'h0000, rd: 1'b1, wr: 1'b0};
        if (gnt == 2'b10) begin
            win_port = PORT_DATA;
            win_req  = '{addr: d_addr, data: d_data_in, rd: d_rd, wr: d_wr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state = is_illegal(win_req) ? ST_ABORT : ST_ISSUE;
                end
            end
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (m_done || m_err) begin
                    next_state = ST_RESP;
                end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
                    next_state = ST_ABORT;
                end
            end
            ST_RESP, ST_ABORT: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered, so this computes what they hold in the next state;
    // leaving IDLE the winner is still on the inputs, not yet in the latches.
    always_comb begin
        eff_grant     = (state == ST_IDLE) ? win_port : grant_q;
        cur_req       = (state == ST_IDLE) ? win_req : lat_q;
        fin           = (next_state == ST_RESP) || (next_state == ST_ABORT);
        rsp_err       = (next_state == ST_ABORT) ? 1'b1 : m_err;
        rsp_data      = (next_state == ST_RESP && m_done && !cur_req.wr) ? m_data_out : 16'h0000;
        m_addr_nxt    = (next_state != ST_IDLE) ? cur_req.addr : 16'h0000;
        m_data_in_nxt = (next_state != ST_IDLE) ? cur_req.data : 16'h0000;
        m_rd_nxt      = (next_state == ST_ISSUE) && cur_req.rd;
        m_wr_nxt      = (next_state == ST_ISSUE) && cur_req.wr;
        i_done_nxt    = fin && (eff_grant == PORT_INST);
        d_done_nxt    = fin && (eff_grant == PORT_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q      <= '0;
            grant_q    <= PORT_INST;
            last_q     <= PORT_INST;
            wd_q       <= '0;
            m_addr     <= 16'h0000;
            m_data_in  <= 16'h0000;
            m_rd       <= 1'b0;
            m_wr       <= 1'b0;
            i_done     <= 1'b0;
            i_err      <= 1'b0;
            i_data_out <= 16'h0000;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            d_data_out <= 16'h0000;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                lat_q   <= win_req;
                grant_q <= win_port;
            end
            if (state == ST_ISSUE) begin
                wd_q <= '0;
            end else if (state == ST_WAIT) begin
                wd_q <= wd_q + CNT_W'(1);
            end
            if (state == ST_RESP || state == ST_ABORT) begin
                last_q <= grant_q;
            end
            m_addr     <= m_addr_nxt;
            m_data_in  <= m_data_in_nxt;
            m_rd       <= m_rd_nxt;
            m_wr       <= m_wr_nxt;
            i_done     <= i_done_nxt;
            i_err      <= i_done_nxt && rsp_err;
            i_data_out <= i_done_nxt ? rsp_data : 16'h0000;
            d_done     <= d_done_nxt;
            d_err      <= d_done_nxt && rsp_err;
            d_data_out <= d_done_nxt ? rsp_data : 16'h0000;
        end
    end

    // A port waiting behind the other keeps its stall high until its own done.
    assign i_stall = i_rd && !i_done;
    assign d_stall = (d_rd || d_wr) && !d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table vectors, hand sequences and randomized
// transactions checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_addr, i_data_out, d_addr, d_data_in, d_data_out;
    logic        i_rd, i_done, i_stall, i_err;
    logic        d_rd, d_wr, d_done, d_stall, d_err;
    logic [15:0] m_addr, m_data_in, m_data_out;
    logic        m_rd, m_wr, m_done, m_stall, m_err;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(T), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_rd(i_rd), .i_data_out(i_data_out),
        .i_done(i_done), .i_stall(i_stall), .i_err(i_err),
        .d_addr(d_addr), .d_data_in(d_data_in), .d_rd(d_rd), .d_wr(d_wr),
        .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall), .d_err(d_err),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
        .m_data_out(m_data_out), .m_done(m_done), .m_stall(m_stall), .m_err(m_err)
    );

    typedef struct {
        logic ir; logic [15:0] ia;
        logic dr; logic dw; logic [15:0] da; logic [15:0] dd;
        int lat; logic inj; int n;
        logic p0; int c0; logic [15:0] x0; logic e0;
        logic p1; int c1; logic [15:0] x1; logic e1;
        int acc; logic [15:0] xa; logic [15:0] xd; logic xw;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // mem_system stand-in: answers mem_lat cycles after an issue (0 = never)
    int          mem_lat = 1;
    logic        mem_err = 1'b0;
    int          acc_count = 0;
    logic [15:0] acc0_addr, acc0_data;
    logic        acc0_wr;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'hA5A5);
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'hA5A5);
    endfunction

    initial begin
        int          pend;
        logic [15:0] pend_addr;
        logic        pend_wr;
        pend = -1; pend_addr = 16'h0; pend_wr = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_data_out = 16'h0; m_stall = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_done = 1'b0; m_err = 1'b0; m_data_out = 16'h0;
            if (rst) begin
                pend = -1;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        m_done = 1'b1;
                        m_err = mem_err;
                        m_data_out = pend_wr ? 16'hDEAD : mem_word(pend_addr);
                        pend = -1;
                    end
                end
                if (m_rd || m_wr) begin
                    if (acc_count == 0) begin
                        acc0_addr = m_addr; acc0_data = m_data_in; acc0_wr = m_wr;
                    end
                    acc_count++;
                    if (m_wr) mem[m_addr] = m_data_in;
                    pend_addr = m_addr; pend_wr = m_wr;
                    pend = (mem_lat == 0) ? -1 : mem_lat;
                end
            end
            m_stall = (pend > 0);
        end
    end

    logic        ev_port [4];
    int          ev_cyc  [4];
    logic [15:0] ev_data [4];
    logic        ev_err  [4];
    int          ev_n;
    logic        exp_port [2];
    int          exp_cyc  [2];
    logic [15:0] exp_data [2];
    logic        exp_err  [2];
    int          exp_n, exp_acc;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic record(input int t0);
        if (i_done) begin
            if (ev_n < 4) begin
                ev_port[ev_n] = 1'b0; ev_cyc[ev_n] = cyc - t0;
                ev_data[ev_n] = i_data_out; ev_err[ev_n] = i_err;
            end
            ev_n++;
        end
        if (d_done) begin
            if (ev_n < 4) begin
                ev_port[ev_n] = 1'b1; ev_cyc[ev_n] = cyc - t0;
                ev_data[ev_n] = d_data_out; ev_err[ev_n] = d_err;
            end
            ev_n++;
        end
    endtask

    // Each requester holds its request until its own done pulse, then drops it.
    task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                                 input logic dw, input logic [15:0] da, input logic [15:0] dd,
                                 input int lat, input logic inj);
        int   t0;
        logic got_i, got_d;
        mem_lat = lat; mem_err = inj; acc_count = 0; ev_n = 0;
        @(posedge clk); #1;
        t0 = cyc;
        i_rd = ir; i_addr = ia; d_rd = dr; d_wr = dw; d_addr = da; d_data_in = dd;
        for (int k = 0; k < 40 && ev_n < exp_n; k++) begin
            @(negedge clk);
            got_i = i_done; got_d = d_done;
            record(t0);
            @(posedge clk); #1;
            if (got_i) i_rd = 1'b0;
            if (got_d) begin d_rd = 1'b0; d_wr = 1'b0; end
        end
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            record(t0);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_eq($sformatf("%s.done_count", tag), ev_n, exp_n);
        for (int k = 0; k < exp_n && k < ev_n; k++) begin
            check_eq($sformatf("%s.ev%0d.port", tag, k), ev_port[k], exp_port[k]);
            check_eq($sformatf("%s.ev%0d.cycle", tag, k), ev_cyc[k], exp_cyc[k]);
            check_eq($sformatf("%s.ev%0d.data", tag, k), ev_data[k], exp_data[k]);
            check_eq($sformatf("%s.ev%0d.err", tag, k), ev_err[k], exp_err[k]);
        end
        check_eq($sformatf("%s.mem_accesses", tag), acc_count, exp_acc);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = {11'h000, 4'($urandom_range(0, 15)), 1'b0};
        if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
        return a;
    endfunction

    vec_t vecs [10];

    initial begin : main
        vec_t        v;
        logic        m_last, ir, dr, dw, inj, ill, p, wr;
        logic        ord [2];
        int          lat, dur, t, n_ord;
        logic [15:0] ia, da, dd, a;
        logic        got;

        #1000000;
        $display("[TB] FAIL global_time_limit: simulation did not finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin : stim
        vec_t        v;
        logic        m_last, ir, dr, dw, inj, ill, p, wr;
        logic        ord [2];
        int          lat, dur, t, n_ord;
        logic [15:0] ia, da, dd, a;
        logic        got;

        vecs[0] = '{1'b1, 16'h0040, 1'b0, 1'b1, 16'h0100, 16'h1234, 1, 1'b0, 2, 1'b1, 3, 16'h0000, 1'b0, 1'b0, 7, 16'hBEEF, 1'b0, 2, 16'h0100, 16'h1234, 1'b1};
        vecs[1] = '{1'b1, 16'h0044, 1'b1, 1'b0, 16'h0100, 16'h0000, 2, 1'b0, 2, 1'b1, 4, 16'h1234, 1'b0, 1'b0, 9, 16'hA5E1, 1'b0, 2, 16'h0100, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0000, 1, 1'b0, 1, 1'b1, 1, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h7777, 1, 1'b0, 1, 1'b1, 1, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 16'h0041, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, 1, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 16'h0000, 3, 1'b1, 1, 1'b0, 5, 16'hA525, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 1, 16'h0080, 16'h0000, 1'b0};
        vecs[6] = '{1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1, 1'b0, 10, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 1, 16'h0100, 16'h0000, 1'b0};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0020, 16'h5A5A, 2, 1'b0, 1, 1'b1, 4, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1, 16'h0020, 16'h5A5A, 1'b1};
        vecs[8] = '{1'b1, 16'h0003, 1'b1, 1'b0, 16'h0020, 16'h0000, 1, 1'b0, 2, 1'b0, 1, 16'h0000, 1'b1, 1'b1, 5, 16'h5A5A, 1'b0, 1, 16'h0020, 16'h0000, 1'b0};
        vecs[9] = '{1'b1, 16'h0050, 1'b1, 1'b1, 16'h0030, 16'h0000, 1, 1'b0, 2, 1'b0, 3, 16'hA5F5, 1'b0, 1'b1, 5, 16'h0000, 1'b1, 1, 16'h0050, 16'h0000, 1'b0};

        mem[16'h0040] = 16'hBEEF;
        rst = 1'b1;
        i_rd = 1'b0; i_addr = 16'h0; d_rd = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_data_in = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset.data_outs", {i_data_out, d_data_out}, 32'h0);
        check_eq("reset.flags", {24'h0, i_done, i_stall, i_err, d_done, d_stall, d_err, m_rd, m_wr}, 32'h0);
        check_eq("reset.mem_bus", {m_addr, m_data_in}, 32'h0);

        // Table vectors; arbitration history carries from row to row.
        for (int r = 0; r < 10; r++) begin
            v = vecs[r];
            exp_n = v.n; exp_acc = v.acc;
            exp_port[0] = v.p0; exp_cyc[0] = v.c0; exp_data[0] = v.x0; exp_err[0] = v.e0;
            exp_port[1] = v.p1; exp_cyc[1] = v.c1; exp_data[1] = v.x1; exp_err[1] = v.e1;
            applyStimulus(v.ir, v.ia, v.dr, v.dw, v.da, v.dd, v.lat, v.inj);
            checkOutput($sformatf("vec%0d", r));
            if (v.acc > 0) begin
                check_eq($sformatf("vec%0d.m_addr", r), acc0_addr, v.xa);
                check_eq($sformatf("vec%0d.m_data_in", r), acc0_data, v.xd);
                check_eq($sformatf("vec%0d.m_wr", r), acc0_wr, v.xw);
            end
        end

        // Cycle-by-cycle shape of a single cache-hit read.
        mem_lat = 1; mem_err = 1'b0;
        @(posedge clk); #1;
        i_rd = 1'b1; i_addr = 16'h0040;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq($sformatf("seq_hit.m_rd[%0d]", k), m_rd, (k == 1));
            check_eq($sformatf("seq_hit.i_done[%0d]", k), i_done, (k == 3));
            check_eq($sformatf("seq_hit.i_stall[%0d]", k), i_stall, (k < 3));
            if (k == 3) check_eq("seq_hit.i_data_out", i_data_out, 16'hBEEF);
            got = i_done;
            @(posedge clk); #1;
            if (got) i_rd = 1'b0;
        end

        // Reset while waiting on memory abandons the transaction.
        mem_lat = 0;
        @(posedge clk); #1;
        i_rd = 1'b1; i_addr = 16'h0060;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("seq_rst.m_rd_issue", m_rd, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; i_rd = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("seq_rst.data_outs", {i_data_out, d_data_out}, 32'h0);
        check_eq("seq_rst.flags", {24'h0, i_done, i_stall, i_err, d_done, d_stall, d_err, m_rd, m_wr}, 32'h0);
        check_eq("seq_rst.mem_bus", {m_addr, m_data_in}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ev_n = 0;
        repeat (12) begin
            @(negedge clk);
            record(cyc);
        end
        check_eq("seq_rst.no_done", ev_n, 0);
        exp_n = 1; exp_acc = 1;
        exp_port[0] = 1'b0; exp_cyc[0] = 3; exp_data[0] = 16'hBEEF; exp_err[0] = 1'b0;
        applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 1, 1'b0);
        checkOutput("seq_rst.fresh");

        // Randomized transactions against a transaction-level model.
        m_last  = 1'b0;
        ref_mem = mem;
        for (int it = 0; it < 150; it++) begin
            ir = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 6))
                2, 3:    begin dr = 1'b1; dw = 1'b0; end
                4, 5:    begin dr = 1'b0; dw = 1'b1; end
                6:       begin dr = 1'b1; dw = 1'b1; end
                default: begin dr = 1'b0; dw = 1'b0; end
            endcase
            if (!ir && !dr && !dw) ir = 1'b1;
            ia = rand_addr(); da = rand_addr(); dd = 16'($urandom);
            lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            inj = ($urandom_range(0, 7) == 0);

            n_ord = 0;
            if (ir && (dr || dw)) begin
                ord[0] = !m_last; ord[1] = m_last; n_ord = 2;
            end else begin
                ord[0] = (dr || dw); n_ord = 1;
            end
            exp_n = n_ord; exp_acc = 0; t = 0;
            for (int j = 0; j < n_ord; j++) begin
                p  = ord[j];
                a  = p ? da : ia;
                wr = p ? dw : 1'b0;
                ill = a[0] || (p && dr && dw);
                exp_port[j] = p;
                if (ill) begin
                    dur = 1; exp_data[j] = 16'h0; exp_err[j] = 1'b1;
                end else begin
                    exp_acc++;
                    if (lat == 0) begin
                        dur = T + 2; exp_data[j] = 16'h0; exp_err[j] = 1'b1;
                    end else begin
                        dur = lat + 2; exp_err[j] = inj;
                        exp_data[j] = wr ? 16'h0 : ref_word(a);
                    end
                    if (wr) ref_mem[a] = dd;
                end
                exp_cyc[j] = t + dur;
                t = t + dur + 1;
                m_last = p;
            end
            applyStimulus(ir, ia, dr, dw, da, dd, lat, inj);
            checkOutput($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares one `mem_system` (cache plus four-bank memory) between the instruction-fetch port and the data port of the processor. It accepts at most one transaction at a time and picks between simultaneous requesters round-robin. It latches the winning request, issues it to `mem_system`, waits for `Done` under a watchdog, and returns the registered result and status to the requester that was granted.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before a transaction is aborted with an error.
- `CNT_W`, default 7: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `i_addr`  in  16  instruction fetch address.
- `i_rd`  in  1  instruction read request.
- `i_data_out`  out  16  fetched word, valid while `i_done`.
- `i_done`  out  1  one-cycle completion pulse for the instruction port.
- `i_stall`  out  1  instruction request pending and not yet done.
- `i_err`  out  1  one-cycle error pulse, coincident with `i_done`.
- `d_addr`  in  16  data address.
- `d_data_in`  in  16  store data.
- `d_rd`  in  1  data read request.
- `d_wr`  in  1  data write request.
- `d_data_out`  out  16  load data, valid while `d_done`.
- `d_done`  out  1  one-cycle completion pulse for the data port.
- `d_stall`  out  1  data request pending and not yet done.
- `d_err`  out  1  one-cycle error pulse, coincident with `d_done`.
- `m_addr`  out  16  to `mem_system` `Addr`.
- `m_data_in`  out  16  to `mem_system` `DataIn`.
- `m_rd`  out  1  to `mem_system` `Rd`.
- `m_wr`  out  1  to `mem_system` `Wr`.
- `m_data_out`  in  16  from `mem_system` `DataOut`.
- `m_done`  in  1  from `mem_system` `Done`.
- `m_stall`  in  1  from `mem_system` `Stall`.
- `m_err`  in  1  from `mem_system` `err`.

## Operation
- **Request handshake:** a requester holds its address, data and request signals stable until its `*_done` pulse. A request is any of `i_rd`, `d_rd` or `d_wr` being high.
- **States:** IDLE, ISSUE, WAIT, RESP, ABORT.
- **IDLE:**
  - With no request, stay in IDLE.
  - Otherwise pick the winner. One requester wins outright; on a tie the winner is the port not equal to `last_grant`.
  - Latch the winner's addr, data, rd and wr into internal registers and record the grant.
  - If the request is illegal, go to ABORT. Illegal means `addr[0]==1` (misaligned) or `d_rd && d_wr`.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - Drive `m_rd`/`m_wr` from the latches for exactly this one cycle.
  - Clear the watchdog.
  - Go to WAIT.
- **WAIT:**
  - `m_rd`/`m_wr` are low.
  - `m_addr`/`m_data_in` hold the latched values in every state except IDLE.
  - The watchdog increments each cycle.
  - On `m_done`: capture `m_data_out` and `m_err`, then go to RESP.
  - If `m_err` is seen without `m_done`: capture the error and go to RESP.
  - If the watchdog reaches TIMEOUT: go to ABORT.
- **RESP:**
  - Pulse the granted port's `*_done`, with `*_data_out` set to the captured data and `*_err` set to the captured error.
  - Update `last_grant`.
  - Go to IDLE.
- **ABORT:**
  - Pulse the granted port's `*_done` and `*_err`, with `*_data_out` = 0.
  - Update `last_grant`.
  - Go to IDLE.
  - No memory access is issued.
- **Stall outputs:** `i_stall` = `i_rd` && !`i_done`; `d_stall` = (`d_rd`||`d_wr`) && !`d_done`. These are combinational; the stall of the port not granted stays high while it waits.
- **Write results:** on a write, `d_data_out` = 0.
- **`m_stall`:** observed only, never gates a transition; `m_done` is authoritative.
- **Reset:**
  - State returns to IDLE; `last_grant` is set to INST, so the first tie goes to data.
  - Every output returns to 0.
  - Reset mid-transaction abandons the transaction; no `done` pulse is generated for it.

## Timing
- Request seen in IDLE at cycle 0; ISSUE at cycle 1; earliest `m_done` at cycle 2.
- The requester's `done` comes one cycle after `m_done` (registered).
- Minimum latency is 3 cycles from request to `done`, on a cache hit.
- Back-to-back: the next grant is evaluated in the IDLE cycle after RESP, so the minimum spacing is 4 cycles per transaction.
- ABORT path: `done` and `err` at cycle 1 for illegal requests. For a timeout, `done` and `err` come TIMEOUT+2 cycles after the request.
- All outputs are registered except `*_stall`.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding;
  - port IDs (INST=0, DATA=1);
  - the default TIMEOUT.
- Sub-module `arb_rr2`: a two-request round-robin picker, combinational. Inputs are `req[1:0]` and `last`; outputs are `gnt[1:0]` (one-hot) and `valid`.
- The top level holds the FSM, the request latches, the watchdog, and the response registers.

## Test plan
- **Single instruction read:** `i_rd`, `i_addr=16'h0040`; `mem_system` returns `m_done` on cycle 2 with `16'hBEEF`. Required: `m_rd` high only on cycle 1; `i_done` on cycle 3 with `i_data_out=16'hBEEF`; `i_err=0`.
- **Simultaneous requests after reset:** `i_rd` with `d_wr` (`d_addr=16'h0100`, `d_data_in=16'h1234`) asserted together. Required:
  - data is served first (`m_wr=1`, `m_addr=16'h0100`, `m_data_in=16'h1234`);
  - instruction is served next without re-arbitration loss;
  - the following tie goes to data.
- **Misaligned access:** `d_rd`, `d_addr=16'h0003`. Required: `d_done`=`d_err`=1 on cycle 1; `m_rd`/`m_wr` never asserted.
- **Illegal data request:** `d_rd`=`d_wr`=1. Required: ABORT with `d_err` pulse; no memory access.
- **Timeout:** `m_done` held low, `TIMEOUT=8`. Required: `i_done`=`i_err`=1 exactly 10 cycles after the request; then IDLE.
- **Reset during WAIT:** assert `rst` at cycle 2. Required: all outputs 0 the next cycle; no `done` pulse; a fresh request afterward completes normally.
